fifo_rd_deser: RTL

- Read-side consumer for the narrow FIFO.
- Pops IN_WIDTH-bit entries through the FIFO's rd_en/empty/rd_data interface and packs WORDS_PER_OUT consecutive entries into one parallel word.
- Presents each word downstream on a valid/ready handshake.
- Runs entirely in the FIFO read-clock domain; the FIFO itself is the only CDC element.

---
 rtl/fifo_rd_deser.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_rd_deser.sv
// FIFO read-side deserializer: pops WORDS_PER_OUT narrow entries and presents them as one word on valid/ready.
// Optional even-parity output enabled by defining FIFO_RD_DESER_PARITY_EN.
module fifo_rd_deser #(
  parameter int IN_WIDTH = 1,
  parameter int WORDS_PER_OUT = 8,
  localparam int OUT_WIDTH = IN_WIDTH * WORDS_PER_OUT,
  localparam int CNT_W = $clog2(WORDS_PER_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FIFO_RD_DESER_PARITY_EN
  output logic                 out_parity,
`endif
  output logic                 busy,
  output logic [15:0]          word_cnt
);

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WORDS_PER_OUT);
  localparam logic [CNT_W-1:0] W_M1  = CNT_W'(WORDS_PER_OUT - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     iss_cnt_reg, iss_cnt_next;
  logic [CNT_W-1:0]     cap_cnt_reg, cap_cnt_next;
  logic                 rd_pending_reg, rd_pending_next;
  logic [OUT_WIDTH-1:0] shift_reg, shift_next;
  logic [OUT_WIDTH-1:0] out_data_reg;
  logic                 out_valid_reg, out_valid_next;
  logic [15:0]          word_cnt_reg, word_cnt_next;
  logic                 cap_en;
  logic                 load_out;

  assign fifo_rd_en = (state_reg == FILL) && !fifo_empty && (iss_cnt_reg < W_CNT)
                      && !flush && !reset;
  // A flush discards the entry that is in flight from the FIFO.
  assign cap_en = rd_pending_reg && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_OUT; gi++) begin : g_slot
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
      assign shift_next[gi*IN_WIDTH +: IN_WIDTH] =
        (cap_en && (cap_cnt_reg == SLOT)) ? fifo_rd_data : shift_reg[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    iss_cnt_next    = iss_cnt_reg;
    cap_cnt_next    = cap_cnt_reg;
    rd_pending_next = 1'b0;
    out_valid_next  = out_valid_reg;
    word_cnt_next   = word_cnt_reg;
    load_out        = 1'b0;
    if (flush) begin
      state_next     = FILL;
      iss_cnt_next   = '0;
      cap_cnt_next   = '0;
      out_valid_next = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        iss_cnt_next    = iss_cnt_reg + 1'b1;
        rd_pending_next = 1'b1;
      end
      if (cap_en) begin
        cap_cnt_next = cap_cnt_reg + 1'b1;
      end
      case (state_reg)
        FILL: begin
          if (fifo_rd_en && (iss_cnt_reg == W_M1)) state_next = DRAIN;
        end
        DRAIN: begin
          // The last capture always lands here, so the output copy includes it.
          if (cap_en && (cap_cnt_reg == W_M1)) begin
            state_next     = HOLD;
            load_out       = 1'b1;
            out_valid_next = 1'b1;
          end
        end
        HOLD: begin
          if (out_valid_reg && out_ready) begin
            state_next     = FILL;
            out_valid_next = 1'b0;
            word_cnt_next  = word_cnt_reg + 16'd1;
            iss_cnt_next   = '0;
            cap_cnt_next   = '0;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FILL;
      iss_cnt_reg    <= '0;
      cap_cnt_reg    <= '0;
      rd_pending_reg <= 1'b0;
      shift_reg      <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      word_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      iss_cnt_reg    <= iss_cnt_next;
      cap_cnt_reg    <= cap_cnt_next;
      rd_pending_reg <= rd_pending_next;
      shift_reg      <= flush ? '0 : shift_next;
      if (load_out) out_data_reg <= shift_next;
      out_valid_reg  <= out_valid_next;
      word_cnt_reg   <= word_cnt_next;
    end
  end

`ifdef FIFO_RD_DESER_PARITY_EN
  logic out_parity_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_parity_reg <= 1'b0;
    end else if (load_out) begin
      out_parity_reg <= ^shift_next;
    end
  end
  assign out_parity = out_parity_reg;
`endif

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (iss_cnt_reg != '0) || rd_pending_reg;
  assign word_cnt  = word_cnt_reg;

endmodule
